fff_latch_reader: RTL and testbench
===================================

Name: fff_latch_reader

Overview:
- Host-side reader and controller for the quad bistable latch that captures contestant buttons in the fastest-finger-first buzzer.
- Synchronises the four latched levels into the clock domain and drives both latch-enable lines, so the latches are transparent while armed and frozen once a press is seen.
- Resolves the first press, reports a one-hot and encoded winner, and pulses a buzzer.
- Sits between the latch outputs and the display/buzzer logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser on each latched bit (legal 2..3).
- BUZZ_CYCLES, 8, buzzer pulse length in clk cycles (legal 1..255).
- TIMEOUT_CYCLES, 1000, answer-window length in clk cycles; used only with FFF_TIMEOUT_EN (legal 1..65535).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  host arm request, level sampled on clk.
- clear  input  1  host clear request, level sampled on clk; has priority over start.
- q  input  4  latched contestant levels: bit0/1 from the pair gated by en_a, bit2/3 from the pair gated by en_b.
- en_a  output  1  latch enable for players 0 and 1; high means transparent.
- en_b  output  1  latch enable for players 2 and 3; high means transparent.
- winner_valid  output  1  high while a winner is held.
- winner_id  output  2  encoded winner index.
- winner_onehot  output  4  one-hot winner.
- tie  output  1  more than one synchronised bit rose in the capture cycle.
- buzzer  output  1  buzzer drive pulse.
- timeout  output  1  answer window expired with no press.
- state  output  2  FSM state: IDLE=0, FLUSH=1, ARMED=2, LOCKED=3.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE; en_a = en_b = 0.
  - winner_valid, winner_id, winner_onehot, tie, buzzer and timeout all 0.
  - Synchroniser flops and buzzer/timeout counters cleared.
- Synchroniser: qs = q delayed by SYNC_STAGES flops. All decisions use qs only.
- IDLE:
  - Enables low.
  - start=1 (with clear=0) moves to FLUSH next cycle.
- FLUSH:
  - Enables high, so the latches follow the buttons.
  - Stays in FLUSH while qs != 0; a stuck button holds FLUSH indefinitely.
  - Moves to ARMED on the first cycle qs == 0.
- ARMED:
  - Enables high.
  - On the first cycle qs != 0, moves to LOCKED next cycle. In that same edge it:
    - drops en_a and en_b;
    - sets winner_onehot to the lowest set bit of qs and winner_id to its index;
    - sets winner_valid=1;
    - sets tie=1 if popcount(qs) > 1;
    - loads the buzzer counter.
  - Simultaneous presses: lowest index wins and tie flags it.
- LOCKED:
  - Enables low and outputs held.
  - buzzer is high for exactly BUZZ_CYCLES cycles, starting the cycle after capture.
  - start is ignored.
  - clear=1 moves to IDLE next cycle and zeroes winner_valid, winner_id, winner_onehot, tie, buzzer and timeout.
- clear=1 in any state moves to IDLE next cycle and drops the enables.
- Presses arriving after capture cannot change the winner: the latches are frozen and qs is ignored.
- buzzer counter saturates at 0; no wrap-around.
- Reset asserted mid-buzzer or mid-ARMED aborts immediately with no residual pulse.

Optional Feature:
- Macro FFF_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to ARMED and increments each ARMED cycle.
  - When it reaches TIMEOUT_CYCLES with qs == 0, the FSM moves to LOCKED, sets timeout=1, drops the enables, and leaves winner_valid=0. No buzzer.
  - A press and expiry in the same cycle resolve as a press: timeout stays 0.
- When not defined: no counter is built, timeout is tied 0, and ARMED waits indefinitely.

Test Plan:
- Reset then idle: rst pulse, q=4'b0000 -> en_a=en_b=0, state=0, all outputs 0.
- Single press: start, q=0 until ARMED, then q=4'b0100 -> LOCKED, winner_id=2, onehot=4'b0100, valid=1, tie=0, buzzer high exactly 8 cycles, enables 0.
- Simultaneous press: q=4'b1010 in the same cycle while ARMED -> winner_id=1, onehot=4'b0010, tie=1; a later q=4'b1111 changes nothing.
- Stuck button: start with q=4'b0001 held 20 cycles -> remains FLUSH (state=1) with enables 1; release -> ARMED SYNC_STAGES+1 cycles later.
- Clear priority: start=1 and clear=1 together in LOCKED -> IDLE next cycle, all winner outputs 0; rst asserted mid-buzzer -> buzzer 0 immediately.
- FFF_TIMEOUT_EN, TIMEOUT_CYCLES=16: arm, no press -> LOCKED after 16 ARMED cycles, timeout=1, winner_valid=0; a press at cycle 16 -> winner reported, timeout=0.

Source files
------------

// File: rtl/fff_latch_reader.sv
// fff_latch_reader: synchronises a quad button latch, arms/freezes it via en_a/en_b and resolves the first press.
// Optional answer-window timeout is built only when FFF_TIMEOUT_EN is defined.
module fff_latch_reader #(
  parameter int SYNC_STAGES    = 2,
  parameter int BUZZ_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic [3:0] q,
  output logic       en_a,
  output logic       en_b,
  output logic       winner_valid,
  output logic [1:0] winner_id,
  output logic [3:0] winner_onehot,
  output logic       tie,
  output logic       buzzer,
  output logic       timeout,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE, FLUSH, ARMED, LOCKED} state_t;
  state_t     state_q, state_d;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] qs, onehot_q, onehot_d;
  logic [1:0] id_q, id_d;
  logic [7:0] buzz_q, buzz_d;
  logic       en_q, en_d, valid_q, valid_d, tie_q, tie_d, timeout_q, timeout_d;
  logic       capture, expire;
  assign qs = sync_q[SYNC_STAGES-1];
  assign capture = (state_q == ARMED) && (qs != 4'd0);
`ifdef FFF_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  // qs==0 in the expiry term makes a coincident press win over the timeout
  assign expire = (state_q == ARMED) && (qs == 4'd0) && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
  always_comb tmo_d = (state_q == ARMED) ? tmo_q + 16'd1 : 16'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_q <= 16'd0;
    else     tmo_q <= tmo_d;
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d   = clear ? IDLE :
                (state_q == IDLE)  ? (start ? FLUSH : IDLE) :
                (state_q == FLUSH) ? ((qs == 4'd0) ? ARMED : FLUSH) :
                (state_q == ARMED) ? ((capture || expire) ? LOCKED : ARMED) : LOCKED;
    en_d      = (state_d == FLUSH) || (state_d == ARMED);
    valid_d   = clear ? 1'b0 : capture ? 1'b1 : valid_q;
    onehot_d  = clear ? 4'd0 : capture ? (qs & (~qs + 4'd1)) : onehot_q;
    id_d      = clear ? 2'd0 : capture ? (qs[0] ? 2'd0 : qs[1] ? 2'd1 : qs[2] ? 2'd2 : 2'd3) : id_q;
    tie_d     = clear ? 1'b0 : capture ? ((qs & (qs - 4'd1)) != 4'd0) : tie_q;
    timeout_d = clear ? 1'b0 : expire ? 1'b1 : timeout_q;
    buzz_d    = clear ? 8'd0 : capture ? 8'(BUZZ_CYCLES) : (buzz_q != 8'd0) ? buzz_q - 8'd1 : 8'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      valid_q   <= 1'b0;
      onehot_q  <= 4'd0;
      id_q      <= 2'd0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
      buzz_q    <= 8'd0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'd0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      valid_q   <= valid_d;
      onehot_q  <= onehot_d;
      id_q      <= id_d;
      tie_q     <= tie_d;
      timeout_q <= timeout_d;
      buzz_q    <= buzz_d;
      sync_q[0] <= q;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign en_a          = en_q;
  assign en_b          = en_q;
  assign winner_valid  = valid_q;
  assign winner_id     = id_q;
  assign winner_onehot = onehot_q;
  assign tie           = tie_q;
  assign buzzer        = buzz_q != 8'd0;
  assign timeout       = timeout_q;
  assign state         = state_q;
endmodule

// File: tb/tb_fff_latch_reader.sv
// tb_fff_latch_reader: directed vector table plus hand sequences for reset/timeout corners.
module tb_fff_latch_reader;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, clear = 1'b0;
  logic [3:0] q = 4'd0;
  logic       en_a, en_b, winner_valid, tie, buzzer, timeout;
  logic [1:0] winner_id, state;
  logic [3:0] winner_onehot;
  int         n_run = 0, n_fail = 0;

  fff_latch_reader #(.SYNC_STAGES(2), .BUZZ_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .q(q),
    .en_a(en_a), .en_b(en_b), .winner_valid(winner_valid), .winner_id(winner_id),
    .winner_onehot(winner_onehot), .tie(tie), .buzzer(buzzer), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, cl; logic [3:0] q; int n;
    logic [1:0] s; logic en, v; logic [1:0] id; logic [3:0] oh; logic tie, bz;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic st, logic cl, logic [3:0] qq, int n, logic [1:0] s, logic en,
                              logic v, logic [1:0] id, logic [3:0] oh, logic ti, logic bz);
    vec_t x;
    x.st = st; x.cl = cl; x.q = qq; x.n = n; x.s = s; x.en = en;
    x.v = v; x.id = id; x.oh = oh; x.tie = ti; x.bz = bz;
    vecs.push_back(x);
  endfunction

  function automatic logic [13:0] outs();
    return {state, en_a, en_b, winner_valid, winner_id, winner_onehot, tie, buzzer, timeout};
  endfunction

  task automatic check(string name, logic [13:0] act, logic [13:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_one(string name, logic act, logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // state, en, valid, id, onehot, tie, buzzer
    add(0,0,4'b0000, 1, 2'd0,0,0,2'd0,4'b0000,0,0);
    add(1,0,4'b0000, 1, 2'd1,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b0000, 1, 2'd2,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b0100, 2, 2'd2,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b0100, 1, 2'd3,0,1,2'd2,4'b0100,0,1);
    add(0,0,4'b0100, 7, 2'd3,0,1,2'd2,4'b0100,0,1);
    add(0,0,4'b0100, 1, 2'd3,0,1,2'd2,4'b0100,0,0);
    add(1,0,4'b0100, 1, 2'd3,0,1,2'd2,4'b0100,0,0);
    add(1,1,4'b0100, 1, 2'd0,0,0,2'd0,4'b0000,0,0);
    add(1,0,4'b0000, 1, 2'd1,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b0000, 1, 2'd1,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b0000, 1, 2'd2,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b1010, 2, 2'd2,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b1111, 1, 2'd3,0,1,2'd1,4'b0010,1,1);
    add(0,0,4'b1111, 3, 2'd3,0,1,2'd1,4'b0010,1,1);
    add(0,1,4'b1111, 1, 2'd0,0,0,2'd0,4'b0000,0,0);
    add(1,0,4'b0001, 1, 2'd1,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b0001,20, 2'd1,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b0000, 2, 2'd1,1,0,2'd0,4'b0000,0,0);
    add(0,0,4'b0000, 1, 2'd2,1,0,2'd0,4'b0000,0,0);
    add(0,1,4'b0000, 1, 2'd0,0,0,2'd0,4'b0000,0,0);

    #1;
    check("reset_async", outs(), 14'd0);
    step(2);
    rst = 1'b0;
    step(1);
    check("reset_idle", outs(), 14'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; clear = vecs[i].cl; q = vecs[i].q;
      step(vecs[i].n);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].s, vecs[i].en, vecs[i].en, vecs[i].v, vecs[i].id, vecs[i].oh, vecs[i].tie, vecs[i].bz, 1'b0});
    end

    start = 1'b0; clear = 1'b0; q = 4'd0;
    start = 1'b1; step(1); start = 1'b0; step(1);
    q = 4'b0001; step(3);
    check("mid_buzz_pre", outs(), {2'd3, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b1, 1'b0});
    #2 rst = 1'b1;
    #1 check("mid_buzz_rst", outs(), 14'd0);
    q = 4'd0;
    step(1); rst = 1'b0; step(1);
    check("post_rst_quiet", outs(), 14'd0);

    start = 1'b1; step(1); start = 1'b0; step(1);
    check_one("armed_state", state == 2'd2, 1'b1);
    #2 rst = 1'b1;
    #1 check("mid_armed_rst", outs(), 14'd0);
    step(1); rst = 1'b0; step(1);

`ifdef FFF_TIMEOUT_EN
    start = 1'b1; step(1); start = 1'b0; step(1);
    step(15);
    check("tmo_wait", outs(), {2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0});
    step(1);
    check("tmo_expire", outs(), {2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
    step(3);
    check_one("tmo_no_buzz", buzzer, 1'b0);
    clear = 1'b1; step(1); clear = 1'b0;
    check("tmo_clear", outs(), 14'd0);
    start = 1'b1; step(1); start = 1'b0; step(1);
    step(13);
    q = 4'b1000; step(2);
    check_one("tmo_race_armed", state == 2'd2, 1'b1);
    step(1);
    check("tmo_race_press", outs(), {2'd3, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1, 1'b0});
`else
    start = 1'b1; step(1); start = 1'b0; step(1);
    step(40);
    check("no_tmo_waits", outs(), {2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0});
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
